// File: rtl/program_ram_arbiter.sv
// Arbitrates the program RAM data port between the CPU load/store unit (port 0)
// and the loader/debug master (port 1), and routes read data back by tag.
module program_ram_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cpu_req_in,
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_we_in,
  output logic        cpu_gnt_out,
  output logic        cpu_rvalid_out,
  input  logic        ldr_req_in,
  input  logic [31:0] ldr_addr_in,
  input  logic [31:0] ldr_data_in,
  input  logic [3:0]  ldr_we_in,
  output logic        ldr_gnt_out,
  output logic        ldr_rvalid_out,
  output logic [31:0] rdata_out,
  output logic [31:0] ram_addr_out,
  output logic [31:0] ram_data_out,
  output logic [3:0]  ram_we_out,
  input  logic [31:0] ram_data_in
);

  // Handshake: a requester holds req/addr/data/we stable until it sees gnt.
  // The request is consumed in the cycle gnt is high. Reads complete exactly
  // READ_LATENCY cycles later with a one-cycle rvalid pulse on the issuing port.

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0]           r_starve_cnt;
  logic [31:0]             r_addr_hold;
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_id;

  logic                    w_ldr_win;
  logic                    w_cpu_gnt;
  logic                    w_ldr_gnt;
  logic                    w_any_gnt;
  logic                    w_rd_issue;
  logic [31:0]             w_addr;
  logic [3:0]              w_we;
  logic [READ_LATENCY-1:0] w_vld_nxt;
  logic [READ_LATENCY-1:0] w_id_nxt;

  // Loader wins when alone, or when it has waited STARVE_LIMIT cycles.
  assign w_ldr_win = ldr_req_in && (!cpu_req_in || (r_starve_cnt == LIMIT_C));
  assign w_ldr_gnt = rst_n_in && w_ldr_win;
  assign w_cpu_gnt = rst_n_in && cpu_req_in && !w_ldr_win;
  assign w_any_gnt = w_cpu_gnt || w_ldr_gnt;

  assign w_addr     = w_ldr_gnt ? ldr_addr_in : cpu_addr_in;
  assign w_we       = w_ldr_gnt ? ldr_we_in : cpu_we_in;
  assign w_rd_issue = w_any_gnt && (w_we == 4'b0000);

  assign cpu_gnt_out  = w_cpu_gnt;
  assign ldr_gnt_out  = w_ldr_gnt;
  assign ram_addr_out = w_any_gnt ? w_addr : r_addr_hold;
  assign ram_data_out = w_ldr_gnt ? ldr_data_in : cpu_data_in;
  assign ram_we_out   = w_any_gnt ? w_we : 4'b0000;

  generate
    if (READ_LATENCY > 1) begin : g_shift
      assign w_vld_nxt = {r_vld[READ_LATENCY-2:0], w_rd_issue};
      assign w_id_nxt  = {r_id[READ_LATENCY-2:0], w_ldr_gnt};
    end else begin : g_single
      assign w_vld_nxt = w_rd_issue;
      assign w_id_nxt  = w_ldr_gnt;
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_starve_cnt <= '0;
      r_addr_hold  <= '0;
      r_vld        <= '0;
      r_id         <= '0;
    end else begin
      if (w_ldr_gnt || !ldr_req_in) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT_C) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
      if (w_any_gnt) begin
        r_addr_hold <= w_addr;
      end
      r_vld <= w_vld_nxt;
      r_id  <= w_id_nxt;
    end
  end

  assign cpu_rvalid_out = r_vld[READ_LATENCY-1] && !r_id[READ_LATENCY-1];
  assign ldr_rvalid_out = r_vld[READ_LATENCY-1] && r_id[READ_LATENCY-1];
  assign rdata_out      = ram_data_in;

endmodule

// File: doc/program_ram_arbiter.md
# program_ram_arbiter

Shares the single data port of the program RAM between two requesters: the CPU load/store unit (port 0) and the program loader/debug master (port 1). The loader writes program images and reads them back for verification. The block picks one winner per cycle and drives the RAM address, data and byte-enables. It tracks outstanding reads through the fixed RAM read latency and returns the read data to the requester that issued each read. Starvation control guarantees the loader forward progress under continuous CPU traffic.

## Interface
Parameters:
- READ_LATENCY, 2, cycles from the grant cycle to valid RAM read data (2 matches the HIGH_PERFORMANCE data port); legal values are 1 to 4.
- STARVE_LIMIT, 8, number of consecutive denied loader cycles after which the loader is forced to win; legal values are 1 to 255.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- cpu_req_in  input  1  CPU access request, valid this cycle.
- cpu_addr_in  input  32  CPU byte address.
- cpu_data_in  input  32  CPU write data.
- cpu_we_in  input  4  CPU byte write enables; 0 means a read.
- cpu_gnt_out  output  1  CPU access accepted this cycle (combinational).
- cpu_rvalid_out  output  1  CPU read data valid.
- ldr_req_in  input  1  loader access request.
- ldr_addr_in  input  32  loader byte address.
- ldr_data_in  input  32  loader write data.
- ldr_we_in  input  4  loader byte write enables; 0 means a read.
- ldr_gnt_out  output  1  loader access accepted this cycle (combinational).
- ldr_rvalid_out  output  1  loader read data valid.
- rdata_out  output  32  read data, shared by both ports; qualified by the rvalid outputs.
- ram_addr_out  output  32  RAM byte address.
- ram_data_out  output  32  RAM write data.
- ram_we_out  output  4  RAM byte enables.
- ram_data_in  input  32  RAM read data.

## Operation
- Winner selection, at most one grant per cycle:
  - CPU has priority by default.
  - The loader wins if only the loader requests, or if starve_cnt == STARVE_LIMIT and the loader requests.
- Starve counter:
  - starve_cnt has width clog2(STARVE_LIMIT+1) and saturates at STARVE_LIMIT.
  - It increments on cycles where ldr_req_in=1 and ldr_gnt_out=0.
  - It clears on a loader grant or when ldr_req_in=0.
- Muxing:
  - ram_addr_out and ram_data_out follow the winner.
  - ram_we_out is the winner's byte enables when a grant occurs, otherwise 4'b0.
  - With no grant, ram_addr_out holds the last granted address; a registered copy, reset value 0.
- Response tracking:
  - A READ_LATENCY-deep shift register carries {valid, id}.
  - It loads {1, winner} on a granted read (we==0) and {0, x} otherwise.
  - The tail drives cpu_rvalid_out when id=0 and ldr_rvalid_out when id=1.
  - rdata_out equals ram_data_in directly.
- Writes produce no rvalid.
- No address range filtering is done here; the RAM wrapper decodes ranges.
- Requesters hold req, addr, data and we until they see gnt. A request is consumed in the cycle its gnt is high.

## Timing
- Reset (rst_n_in=0, asynchronous):
  - Shift register, starve_cnt and the held address clear.
  - cpu_gnt_out, ldr_gnt_out, cpu_rvalid_out and ldr_rvalid_out are 0.
  - ram_we_out is 0 and ram_addr_out is 0.
  - While reset is asserted, grants are forced to 0 regardless of requests.
- Reads issued before a mid-operation reset never return an rvalid.
- Grant is combinational in the same cycle as req. A read granted in cycle N gives rvalid in cycle N+READ_LATENCY.
- Back-to-back grants every cycle are allowed; rvalid pulses are then consecutive and in issue order.
- With both requesting continuously, the loader is granted on every (STARVE_LIMIT+1)-th cycle, and the CPU on the rest.
- A loader request dropped while waiting clears starve_cnt. A later request restarts the count from 0.
- Simultaneous loader grant and starve_cnt==STARVE_LIMIT: the counter clears the next cycle.

## Test plan
- Reset behaviour: hold rst_n_in=0 with both req=1 -> both gnt=0, ram_we_out=0. Release reset -> the CPU is granted first.
- Single CPU read: CPU read at 0x0002_0010 in cycle N -> ram_addr_out=0x0002_0010 in cycle N. cpu_rvalid_out=1 in N+2 with rdata_out equal to the RAM model word. ldr_rvalid_out stays 0.
- Loader write: loader writes 0xDEADBEEF with we=4'hF, then reads it back -> ram_we_out=4'hF for one cycle. ldr_rvalid_out fires 2 cycles after the read grant with data 0xDEADBEEF.
- Contention with starvation: both request reads continuously for 30 cycles with STARVE_LIMIT=8 -> loader grants at cycles 8, 17 and 26 (counting from 0). Every grant returns exactly one rvalid to the correct port, in order.
- Interleaved tags: alternate CPU and loader reads every cycle -> rvalid alternates between the ports with a fixed 2-cycle lag. Writes in the stream produce no rvalid.
- Reset mid-read: reads granted in cycles N and N+1, then rst_n_in pulses low in cycle N+1 -> no rvalid in N+2 or N+3, and starve_cnt is 0.
